// File: rtl/bch_correct_stream_pkg.sv
// Shared types and sizing helpers for the BCH correction stream stage.
// Frame geometry and buffer widths are derived from module parameters through these functions.
package bch_correct_stream_pkg;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_CORRECT = 1'b1
   } state_t;

   function automatic int frame_words(input int k, input int bits);
      return k / bits;
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int fill_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width of a down-counter that must hold values up to words-1.
   function automatic int words_left_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/bch_correct_stream_word_buffer.sv
// Single-clock circular word buffer holding received data until the locator catches up.
// Head word is read combinationally so a pop and its data land in the same cycle.
module bch_word_buffer
   import bch_correct_stream_pkg::*;
#(
   parameter int BITS  = 4,
   parameter int DEPTH = 8,
   localparam int PTR_W  = ptr_width(DEPTH),
   localparam int FILL_W = fill_width(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [BITS-1:0]   wr_data,
   input  logic              pop,
   output logic [BITS-1:0]   head,
   output logic [FILL_W-1:0] fill,
   output logic              full,
   output logic              empty
);

   logic [BITS-1:0]   buf_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              do_wr;
   logic              do_pop;

   assign full  = (fill_q == FILL_W'(DEPTH));
   assign empty = (fill_q == '0);
   assign fill  = fill_q;
   assign head  = buf_mem[rd_ptr_q];

   always_comb begin
      do_wr    = wr_en && !full;
      do_pop   = pop && !empty;
      // Pointers wrap naturally because DEPTH is a power of two.
      wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      fill_d   = fill_q + FILL_W'(do_wr) - FILL_W'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         buf_mem[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
      end
   end

endmodule

// File: rtl/bch_correct_stream.sv
// Applies Chien locator error words to buffered received data and streams corrected words.
// Tracks flipped bits per frame and flags a decode failure when the count disagrees with deg(sigma).
module bch_correct_stream
   import bch_correct_stream_pkg::*;
#(
   parameter int K     = 16,
   parameter int T     = 2,
   parameter int BITS  = 4,
   parameter int DEPTH = 8,
   parameter int CNT_W = 8,
   localparam int EXP_W = $clog2(T + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [BITS-1:0]  data_in,
   input  logic             data_valid,
   output logic             data_ready,
   input  logic             err_first,
   input  logic [BITS-1:0]  err,
   input  logic [EXP_W-1:0] err_expected,
   output logic [BITS-1:0]  out_data,
   output logic             out_valid,
   output logic             out_last,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic             fail,
   output logic             underflow,
   output logic             protocol_err
);

   localparam int FW     = frame_words(K, BITS);
   localparam int WL_W   = words_left_width(FW);
   localparam int FILL_W = fill_width(DEPTH);
   localparam int PC_W   = $clog2(BITS + 1);
   localparam bit SINGLE_WORD = (FW == 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [BITS-1:0]   buf_head;
   logic [FILL_W-1:0] buf_fill;
   logic              buf_full;
   logic              buf_empty;
   logic              buf_wr;

   state_t            state_q, state_d;
   logic [WL_W-1:0]   words_left_q, words_left_d;
   logic [EXP_W-1:0]  exp_q, exp_d;
   logic [CNT_W-1:0]  accum_q, accum_d;
   logic              sat_q, sat_d;
   logic [BITS-1:0]   out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  err_count_q, err_count_d;
   logic              fail_q, fail_d;
   logic              underflow_q, underflow_d;
   logic              protocol_err_q, protocol_err_d;

   logic              start;
   logic              proc;
   logic              last;
   logic [PC_W-1:0]   err_pop;
   logic [CNT_W-1:0]  acc_base;
   logic              sat_base;
   logic [EXP_W-1:0]  exp_cur;
   logic [CNT_W:0]    sum;
   logic [CNT_W-1:0]  acc_new;
   logic              sat_new;

   assign buf_wr     = data_valid && !buf_full;
   assign data_ready = (buf_fill < FILL_W'(DEPTH));

   bch_word_buffer #(
      .BITS  (BITS),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (buf_wr),
      .wr_data (data_in),
      .pop     (proc),
      .head    (buf_head),
      .fill    (buf_fill),
      .full    (buf_full),
      .empty   (buf_empty)
   );

   always_comb begin
      err_pop = '0;
      for (int i = 0; i < BITS; i++) begin
         err_pop = err_pop + PC_W'(err[i]);
      end
   end

   always_comb begin
      start    = (state_q == ST_IDLE) && err_first;
      proc     = start || (state_q == ST_CORRECT);
      acc_base = start ? '0 : accum_q;
      sat_base = start ? 1'b0 : sat_q;
      exp_cur  = start ? err_expected : exp_q;
      // The extra top bit of sum flags a count that no longer fits the counter.
      sum      = {1'b0, acc_base} + (CNT_W + 1)'(err_pop);
      acc_new  = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
      sat_new  = sat_base | sum[CNT_W];
      last     = start ? SINGLE_WORD : (words_left_q == WL_W'(1));

      state_d        = state_q;
      words_left_d   = words_left_q;
      exp_d          = exp_q;
      accum_d        = accum_q;
      sat_d          = sat_q;
      out_data_d     = out_data_q;
      out_valid_d    = proc;
      out_last_d     = proc && last;
      done_d         = proc && last;
      err_count_d    = err_count_q;
      fail_d         = fail_q;
      underflow_d    = underflow_q;
      protocol_err_d = protocol_err_q;

      if ((state_q == ST_CORRECT) && err_first) begin
         protocol_err_d = 1'b1;
      end

      if (proc) begin
         // An empty buffer still emits the error word so the frame keeps its length.
         out_data_d = buf_empty ? err : (buf_head ^ err);
         if (buf_empty) begin
            underflow_d = 1'b1;
         end
         accum_d      = acc_new;
         sat_d        = sat_new;
         exp_d        = exp_cur;
         words_left_d = start ? WL_W'(FW - 1) : (words_left_q - WL_W'(1));
         if (last) begin
            state_d     = ST_IDLE;
            err_count_d = acc_new;
            fail_d      = (acc_new != CNT_W'(exp_cur)) | sat_new;
         end else begin
            state_d = ST_CORRECT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         words_left_q   <= '0;
         exp_q          <= '0;
         accum_q        <= '0;
         sat_q          <= 1'b0;
         out_data_q     <= '0;
         out_valid_q    <= 1'b0;
         out_last_q     <= 1'b0;
         done_q         <= 1'b0;
         err_count_q    <= '0;
         fail_q         <= 1'b0;
         underflow_q    <= 1'b0;
         protocol_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         words_left_q   <= words_left_d;
         exp_q          <= exp_d;
         accum_q        <= accum_d;
         sat_q          <= sat_d;
         out_data_q     <= out_data_d;
         out_valid_q    <= out_valid_d;
         out_last_q     <= out_last_d;
         done_q         <= done_d;
         err_count_q    <= err_count_d;
         fail_q         <= fail_d;
         underflow_q    <= underflow_d;
         protocol_err_q <= protocol_err_d;
      end
   end

   assign out_data     = out_data_q;
   assign out_valid    = out_valid_q;
   assign out_last     = out_last_q;
   assign done         = done_q;
   assign err_count    = err_count_q;
   assign fail         = fail_q;
   assign underflow    = underflow_q;
   assign protocol_err = protocol_err_q;

endmodule
